// File: rtl/pps_monitor.sv
// pps_monitor: receive side of the 1 Hz PPS interface.
// Measures the period between PPS rising edges and checks it against CLK_DIV +/- TOL.
// Declares lock after LOCK_CNT consecutive good periods.
// Regenerates a clean one-cycle pps_out and keeps a seconds count.
// When the input disappears it free-runs in holdover for up to HOLD_MAX ticks.
module pps_monitor #(
  parameter logic [31:0] CLK_DIV  = 32'd50_000_000,
  parameter logic [31:0] TOL      = 32'd5_000,
  parameter logic [3:0]  LOCK_CNT = 4'd3,
  parameter logic [15:0] HOLD_MAX = 16'd10
) (
  input  logic        clk_50m,
  input  logic        reset_n,
  input  logic        pps_in,
  output logic [31:0] period,
  output logic        period_valid,
  output logic        pps_out,
  output logic [15:0] second,
  output logic        locked,
  output logic        holdover,
  output logic        pps_missing,
  output logic [7:0]  err_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACQ    = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic [31:0] PER_LO = CLK_DIV - TOL;
  localparam logic [31:0] PER_HI = CLK_DIV + TOL;
  localparam logic [31:0] WRAP   = CLK_DIV - 32'd1;

  logic        s1, s2, s3;
  logic        rise, good, timeout;
  logic [31:0] cnt, cnt_inc;
  logic [1:0]  state, state_n;
  logic [3:0]  good_cnt, good_cnt_n;
  logic [31:0] hold_cnt, hold_cnt_n;
  logic [15:0] hold_sec, hold_sec_n;
  logic        tick, miss, err;

  assign rise    = s2 & ~s3;
  assign cnt_inc = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  assign good    = (cnt_inc >= PER_LO) && (cnt_inc <= PER_HI);
  assign timeout = (cnt == PER_HI) && !rise;

  // Two-flop synchroniser for the asynchronous pin, plus one delay stage for edge detection
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) {s3, s2, s1} <= 3'b000;
    else          {s3, s2, s1} <= {s2, s1, pps_in};
  end

  // Next-state and event decode; a rise always takes priority over timeout or a holdover tick
  always_comb begin
    state_n    = state;
    good_cnt_n = good_cnt;
    hold_cnt_n = hold_cnt;
    hold_sec_n = hold_sec;
    tick       = 1'b0;
    miss       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n    = ACQ;
          good_cnt_n = 4'd0;
        end
      end
      ACQ: begin
        if (rise) begin
          if (good) begin
            good_cnt_n = good_cnt + 4'd1;
            if (good_cnt + 4'd1 == LOCK_CNT) begin
              state_n = LOCKED;
              tick    = 1'b1;
            end
          end else begin
            good_cnt_n = 4'd0;
            err        = 1'b1;
          end
        end else if (timeout) begin
          state_n = IDLE;
          miss    = 1'b1;
          err     = 1'b1;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (good) begin
            tick = 1'b1;
          end else begin
            state_n    = ACQ;
            good_cnt_n = 4'd0;
            err        = 1'b1;
          end
        end else if (timeout) begin
          state_n    = HOLD;
          miss       = 1'b1;
          err        = 1'b1;
          tick       = 1'b1;
          hold_cnt_n = 32'd0;
          hold_sec_n = 16'd1;
        end
      end
      default: begin
        if (rise) begin
          state_n    = ACQ;
          good_cnt_n = 4'd0;
        end else if (hold_cnt == WRAP) begin
          hold_cnt_n = 32'd0;
          if (hold_sec == HOLD_MAX) begin
            state_n = IDLE;
          end else begin
            tick       = 1'b1;
            hold_sec_n = hold_sec + 16'd1;
          end
        end else begin
          hold_cnt_n = hold_cnt + 32'd1;
        end
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= 32'd0;
      state        <= IDLE;
      good_cnt     <= 4'd0;
      hold_cnt     <= 32'd0;
      hold_sec     <= 16'd0;
      period       <= 32'd0;
      period_valid <= 1'b0;
      pps_out      <= 1'b0;
      second       <= 16'd0;
      locked       <= 1'b0;
      holdover     <= 1'b0;
      pps_missing  <= 1'b0;
      err_cnt      <= 8'd0;
    end else begin
      cnt          <= rise ? 32'd0 : cnt_inc;
      state        <= state_n;
      good_cnt     <= good_cnt_n;
      hold_cnt     <= hold_cnt_n;
      hold_sec     <= hold_sec_n;
      // A rise seen from IDLE has no preceding edge to measure against
      period_valid <= rise && (state != IDLE);
      if (rise && (state != IDLE)) period <= cnt_inc;
      pps_out      <= tick;
      if (tick) second <= second + 16'd1;
      pps_missing  <= miss;
      if (err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      locked       <= (state_n == LOCKED);
      holdover     <= (state_n == HOLD);
    end
  end

endmodule

// File: tb/tb_pps_monitor.sv
// Directed bench for pps_monitor with CLK_DIV=100, TOL=5, LOCK_CNT=3, HOLD_MAX=2.
// Inputs change 1 ns after a rising clock edge; outputs are sampled at that same point.
module tb_pps_monitor;

  logic        clk_50m = 1'b0;
  logic        reset_n = 1'b0;
  logic        pps_in  = 1'b0;
  logic [31:0] period;
  logic        period_valid;
  logic        pps_out;
  logic [15:0] second;
  logic        locked;
  logic        holdover;
  logic        pps_missing;
  logic [7:0]  err_cnt;

  int tests = 0;
  int fails = 0;
  int pv_seen;

  pps_monitor #(
    .CLK_DIV (32'd100),
    .TOL     (32'd5),
    .LOCK_CNT(4'd3),
    .HOLD_MAX(16'd2)
  ) dut (
    .clk_50m     (clk_50m),
    .reset_n     (reset_n),
    .pps_in      (pps_in),
    .period      (period),
    .period_valid(period_valid),
    .pps_out     (pps_out),
    .second      (second),
    .locked      (locked),
    .holdover    (holdover),
    .pps_missing (pps_missing),
    .err_cnt     (err_cnt)
  );

  always #5 clk_50m = ~clk_50m;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clk_50m);
    #1;
  endtask

  // 1-clk pulse; returns 1 ns after the edge where the rise takes effect
  task automatic pulse();
    pps_in = 1'b1;
    step(1);
    pps_in = 1'b0;
    step(2);
  endtask

  // Rise taking effect exactly p clocks after the previous one
  task automatic gap_pulse(input int p);
    step(p - 3);
    pulse();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    // Reset state
    step(3);
    check("rst_period", period, 0);
    check("rst_pv", period_valid, 0);
    check("rst_pps", pps_out, 0);
    check("rst_second", second, 0);
    check("rst_locked", locked, 0);
    check("rst_hold", holdover, 0);
    check("rst_miss", pps_missing, 0);
    check("rst_err", err_cnt, 0);
    reset_n = 1'b1;
    step(2);

    // 1. Six rises 100 clk apart
    pulse();
    check("t1_r1_pv", period_valid, 0);
    gap_pulse(100);
    check("t1_r2_pv", period_valid, 1);
    check("t1_r2_period", period, 100);
    check("t1_r2_locked", locked, 0);
    gap_pulse(100);
    check("t1_r3_locked", locked, 0);
    check("t1_r3_pps", pps_out, 0);
    gap_pulse(100);
    check("t1_r4_locked", locked, 1);
    check("t1_r4_pps", pps_out, 1);
    check("t1_r4_second", second, 1);
    step(1);
    check("t1_pps_1cyc", pps_out, 0);
    check("t1_pv_1cyc", period_valid, 0);
    gap_pulse(99);
    check("t1_r5_second", second, 2);
    gap_pulse(100);
    check("t1_r6_second", second, 3);

    // 2. Tolerance edges, then a bad period
    gap_pulse(95);
    check("t2_95_period", period, 95);
    check("t2_95_pps", pps_out, 1);
    check("t2_95_second", second, 4);
    gap_pulse(105);
    check("t2_105_period", period, 105);
    check("t2_105_pps", pps_out, 1);
    check("t2_105_locked", locked, 1);
    gap_pulse(94);
    check("t2_94_period", period, 94);
    check("t2_94_pv", period_valid, 1);
    check("t2_94_err", err_cnt, 1);
    check("t2_94_locked", locked, 0);
    check("t2_94_pps", pps_out, 0);
    check("t2_94_second", second, 5);

    // 3. Relock, then stop the input
    gap_pulse(100);
    gap_pulse(100);
    gap_pulse(100);
    check("t3_relock", locked, 1);
    check("t3_relock_sec", second, 6);
    step(105);
    check("t3_pre_miss", pps_missing, 0);
    check("t3_pre_hold", holdover, 0);
    step(1);
    check("t3_miss", pps_missing, 1);
    check("t3_hold", holdover, 1);
    check("t3_locked", locked, 0);
    check("t3_pps", pps_out, 1);
    check("t3_second", second, 7);
    check("t3_err", err_cnt, 2);
    step(1);
    check("t3_miss_1cyc", pps_missing, 0);
    step(98);
    check("t3_pre_tick", pps_out, 0);
    step(1);
    check("t3_tick", pps_out, 1);
    check("t3_tick_sec", second, 8);
    check("t3_tick_hold", holdover, 1);
    step(99);
    check("t3_pre_idle_hold", holdover, 1);
    step(1);
    check("t3_idle_hold", holdover, 0);
    check("t3_idle_pps", pps_out, 0);
    check("t3_idle_second", second, 8);
    check("t3_idle_err", err_cnt, 2);

    // 4. Rise during holdover
    step(5);
    pulse();
    check("t4_idle_pv", period_valid, 0);
    gap_pulse(100);
    gap_pulse(100);
    gap_pulse(100);
    check("t4_locked", locked, 1);
    check("t4_second", second, 9);
    step(106);
    check("t4_hold", holdover, 1);
    check("t4_hold_sec", second, 10);
    check("t4_hold_err", err_cnt, 3);
    step(20);
    pulse();
    check("t4_exit_hold", holdover, 0);
    check("t4_pv", period_valid, 1);
    check("t4_period", period, 129);
    check("t4_err", err_cnt, 3);
    check("t4_pps", pps_out, 0);
    check("t4_locked", locked, 0);

    // 5. Reset while locked
    gap_pulse(100);
    gap_pulse(100);
    gap_pulse(100);
    check("t5_locked", locked, 1);
    check("t5_second", second, 11);
    step(10);
    reset_n = 1'b0;
    step(3);
    check("t5_rst_locked", locked, 0);
    check("t5_rst_second", second, 0);
    check("t5_rst_err", err_cnt, 0);
    check("t5_rst_period", period, 0);
    check("t5_rst_hold", holdover, 0);
    reset_n = 1'b1;
    step(2);
    pulse();
    check("t5_first_pv", period_valid, 0);
    check("t5_first_locked", locked, 0);

    // 6. Long high level gives one rise; then error saturation
    pps_in = 1'b1;
    pv_seen = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (period_valid) pv_seen++;
    end
    pps_in = 1'b0;
    check("t6_one_rise", pv_seen, 1);
    check("t6_err_after_high", err_cnt, 2);
    step(5);
    for (int i = 0; i < 10; i++) gap_pulse(50);
    check("t6_err_mid", err_cnt, 11);
    for (int i = 0; i < 290; i++) gap_pulse(50);
    check("t6_err_sat", err_cnt, 255);
    check("t6_locked", locked, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
